alu_arbiter: RTL and testbench

Shares the single combinational ALU (33-bit result, 32-bit operands, 3-bit select s2/s1/s0) between two requesters. Each requester issues operations with a valid/ready handshake, and a round-robin policy arbitrates between them. The block drives the ALU from registered operands, captures the result one cycle later, and returns it on a response channel tagged with the requester ID. It sits between the ALU and its two clients (for example the issue stage and the debug port).

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result is captured and returned tagged with its requester.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_s2,
    output logic             alu_s1,
    output logic             alu_s0,
    input  logic [WIDTH:0]   alu_res,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_res,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters hold valid and payload stable until ready; the response holds until rsp_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       op_q, op_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_res_q, rsp_res_d;

    logic grant_vld;
    logic grant;
    logic accept;

    // A tie goes to whoever was not granted last; a lone requester always wins.
    assign grant_vld  = req0_valid | req1_valid;
    assign grant      = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    assign accept     = (state_q == IDLE) && grant_vld && !rst;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_res_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_res_q   <= rsp_res_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_res_d   = rsp_res_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    alu_a_d  = grant ? req1_a : req0_a;
                    alu_b_d  = grant ? req1_b : req0_b;
                    op_d     = grant ? req1_op : req0_op;
                    rsp_id_d = grant;
                    last_d   = grant;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_res_d   = alu_res;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_s2    = op_q[2];
    assign alu_s1    = op_q[1];
    assign alu_s0    = op_q[0];
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_res   = rsp_res_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an adder ALU stub and per-scenario inline checks.
module tb_alu_arbiter;
    localparam int WIDTH = 32;

    logic             clk;
    logic             rst;
    logic             req0_valid, req0_ready;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic [2:0]       req0_op;
    logic             req1_valid, req1_ready;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic             alu_s2, alu_s1, alu_s0;
    logic [WIDTH:0]   alu_res;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [WIDTH:0]   rsp_res;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_s2(alu_s2), .alu_s1(alu_s1), .alu_s0(alu_s0),
        .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_res(rsp_res), .busy(busy), .dbg_state(dbg_state)
    );

    // ALU stub: plain add regardless of select
    assign alu_res = {1'b0, alu_a} + {1'b0, alu_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge after inputs are set; returns at #1 past the negedge where a ready is seen.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (req0_ready || req1_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h1; req0_op = 3'b111;
        req1_valid = 1'b1; req1_a = 32'h5678; req1_b = 32'h2; req1_op = 3'b111;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            n_errors++; $display("FAIL reset_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        n_checks++;
        if ({rsp_valid, rsp_id, busy} !== 3'b000) begin
            n_errors++; $display("FAIL reset_rsp: got %b expected 000", {rsp_valid, rsp_id, busy});
        end
        n_checks++;
        if ({rsp_res, alu_a, alu_b, alu_s2, alu_s1, alu_s0} !== '0) begin
            n_errors++; $display("FAIL reset_data: rsp_res=%h alu_a=%h alu_b=%h expected all 0", rsp_res, alu_a, alu_b);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; req0_op = 3'b010;
        rsp_ready = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if ({busy, dbg_state, alu_a, alu_s2, alu_s1, alu_s0} !== {1'b1, 2'd1, 32'hFFFF_FFFF, 3'b010}) begin
            n_errors++; $display("FAIL single_exec: busy=%b state=%0d alu_a=%h sel=%b%b%b expected 1 1 ffffffff 010",
                                 busy, dbg_state, alu_a, alu_s2, alu_s1, alu_s0);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b0, 33'h1_0000_0000}) begin
            n_errors++; $display("FAIL single_rsp: valid=%b id=%b res=%h expected 1 0 100000000", rsp_valid, rsp_id, rsp_res);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            n_errors++; $display("FAIL single_done: valid=%b busy=%b expected 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_contention();
        bit ok;
        int last_cyc;
        logic exp_g;
        logic [WIDTH:0] exp_res;
        logic [2:0] exp_op;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd5;  req0_b = 32'd3;  req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd20; req1_op = 3'b110;
        rsp_ready = 1'b1;
        last_cyc = -1;
        for (int k = 0; k < 4; k++) begin
            exp_g   = k[0];
            exp_res = exp_g ? 33'd30 : 33'd8;
            exp_op  = exp_g ? 3'b110 : 3'b001;
            wait_grant(ok);
            n_checks++;
            if (!ok) begin
                n_errors++; $display("FAIL cont_timeout: op %0d no grant within bound", k);
                return;
            end
            n_checks++;
            if ({req1_ready, req0_ready} !== {exp_g, ~exp_g}) begin
                n_errors++; $display("FAIL cont_grant: op %0d got r1r0=%b expected %b", k, {req1_ready, req0_ready}, {exp_g, ~exp_g});
            end
            if (last_cyc >= 0) begin
                n_checks++;
                if (cyc - last_cyc !== 3) begin
                    n_errors++; $display("FAIL cont_spacing: op %0d got %0d cycles expected 3", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            @(posedge clk); #1;
            n_checks++;
            if ({alu_s2, alu_s1, alu_s0} !== exp_op) begin
                n_errors++; $display("FAIL cont_sel: op %0d got %b expected %b", k, {alu_s2, alu_s1, alu_s0}, exp_op);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, exp_g, exp_res}) begin
                n_errors++; $display("FAIL cont_rsp: op %0d valid=%b id=%b res=%0d expected 1 %b %0d", k, rsp_valid, rsp_id, rsp_res, exp_g, exp_res);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd9; req0_op = 3'b011;
        req1_a = 32'd1; req1_b = 32'd1; req1_op = 3'b000;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req1_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_res, busy, req0_ready, req1_ready} !== {1'b1, 1'b0, 33'd16, 1'b1, 2'b00}) begin
                n_errors++; $display("FAIL bp_hold: cycle %0d valid=%b id=%b res=%0d busy=%b r0=%b r1=%b expected 1 0 16 1 0 0",
                                     i, rsp_valid, rsp_id, rsp_res, busy, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({rsp_valid, busy, req0_ready, req1_ready} !== 4'b0001) begin
            n_errors++; $display("FAIL bp_release: valid=%b busy=%b r0=%b r1=%b expected 0 0 0 1", rsp_valid, busy, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd40; req0_b = 32'd2; req0_op = 3'b101;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, busy, rsp_res, alu_a, alu_b, alu_s2, alu_s1, alu_s0} !== '0) begin
            n_errors++; $display("FAIL midrst_outputs: valid=%b busy=%b alu_a=%h sel=%b%b%b expected all 0",
                                 rsp_valid, busy, alu_a, alu_s2, alu_s1, alu_s0);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_errors++; $display("FAIL midrst_ghost: got rsp_valid after reset, expected none");
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            n_errors++; $display("FAIL midrst_tie: got r0r1=%b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200; req1_op = 3'b101;
        req0_a = 32'd1; req0_b = 32'd2; req0_op = 3'b000;
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(ok);
            n_checks++;
            if ({ok, req0_ready, req1_ready} !== 3'b101) begin
                n_errors++; $display("FAIL fair_grant: op %0d ok=%b r0=%b r1=%b expected 1 0 1", k, ok, req0_ready, req1_ready);
            end
            repeat (2) @(posedge clk);
            #1;
            n_checks++;
            if ({rsp_valid, rsp_id, rsp_res} !== {1'b1, 1'b1, 33'd300}) begin
                n_errors++; $display("FAIL fair_rsp: op %0d valid=%b id=%b res=%0d expected 1 1 300", k, rsp_valid, rsp_id, rsp_res);
            end
            if (k == 2) req0_valid = 1'b1;
            @(negedge clk);
        end
        wait_grant(ok);
        n_checks++;
        if ({ok, req0_ready, req1_ready} !== 3'b110) begin
            n_errors++; $display("FAIL fair_switch: ok=%b r0=%b r1=%b expected 1 1 0", ok, req0_ready, req1_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_fairness();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
